// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions (32-bit data, 8-bit source) shared by host and device blocks.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  // Fixed integrity pattern returned with every response.
  localparam tl_d_user_t TL_D_USER_DEFAULT = '{rsp_intg: 7'h2a, data_intg: 7'h55};

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_rsp_mem_pkg.sv
// Response types and request-checking helpers for the TL-UL memory responder.
package tlul_rsp_mem_pkg;
  import tlul_pkg::*;

  typedef struct packed {
    tl_d_op_e   d_opcode;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic       error;
  } rsp_meta_t;

  typedef struct packed {
    rsp_meta_t   meta;
    logic [31:0] data;
  } rsp_entry_t;

  function automatic logic [31:0] mask_expand(input logic [3:0] mask);
    logic [31:0] bits;
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

  // The window base is aligned to its size, so range membership reduces to
  // comparing the address bits above the window offset.
  function automatic logic req_err(input tl_h2d_t req, input logic [31:0] base,
                                   input int unsigned aw);
    logic [3:0] lane;
    logic bad_op, bad_size, misalign, out_rng, bad_full, bad_mask;
    bad_op   = !(req.a_opcode inside {Get, PutFullData, PutPartialData});
    bad_size = req.a_size > 2'd2;
    misalign = (req.a_size == 2'd1 && req.a_address[0]) ||
               (req.a_size == 2'd2 && req.a_address[1:0] != 2'b00);
    out_rng  = (req.a_address >> (aw + 2)) != (base >> (aw + 2));
    case (req.a_size)
      2'd0:    lane = 4'b0001 << req.a_address[1:0];
      2'd1:    lane = 4'b0011 << {req.a_address[1], 1'b0};
      default: lane = 4'b1111;
    endcase
    bad_full = (req.a_opcode == PutFullData) && (req.a_mask != lane);
    bad_mask = (req.a_mask == 4'h0) || ((req.a_mask & ~lane) != 4'h0);
    return bad_op | bad_size | misalign | out_rng | bad_full | bad_mask;
  endfunction

endpackage

// File: rtl/tlul_rsp_mem_fifo.sv
// In-order response FIFO (tlul_rsp_fifo) holding responses that could not leave the
// pending stage; simultaneous push and pop keep the count unchanged.
module tlul_rsp_fifo
  import tlul_rsp_mem_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CW    = $clog2(Depth + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rsp_entry_t    wdata,
  input  logic          pop,
  output rsp_entry_t    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;

  rsp_entry_t    store [Depth];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(Depth - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= wdata;
  end

  assign rdata = store[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(Depth));

endmodule

// File: rtl/tlul_rsp_mem.sv
// TL-UL device bridging a host port to a single-port synchronous word memory.
// Define TLUL_RSP_MEM_WRPROT_EN for ROM mode: every Put* is rejected with d_error.
module tlul_rsp_mem
  import tlul_pkg::*;
  import tlul_rsp_mem_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter int unsigned Depth    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  tl_h2d_t       tl_i,
  output tl_d2h_t       tl_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [31:0]   mem_wmask_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned CW = $clog2(Depth + 1);

  logic          a_ready, acc, err, is_put;
  logic [31:0]   off;
  logic          pend_valid;
  rsp_meta_t     pend_meta, acc_meta;
  rsp_entry_t    pend_entry, head, out_entry;
  logic          push, pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   inflight;
  logic          unused_sig;

  // Acceptance depends only on occupancy so a_ready never looks at a_valid.
  assign inflight = {1'b0, fifo_count} + (CW+1)'(pend_valid);
  assign a_ready  = !rst_i && (inflight < (CW+1)'(Depth));
  assign acc      = tl_i.a_valid && a_ready;
  assign is_put   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);

`ifdef TLUL_RSP_MEM_WRPROT_EN
  assign err       = req_err(tl_i, BaseAddr, AW) || is_put;
  assign mem_req_o = acc && !err;
  assign mem_we_o  = 1'b0;
`else
  assign err       = req_err(tl_i, BaseAddr, AW);
  assign mem_req_o = acc && !err;
  assign mem_we_o  = mem_req_o && is_put;
`endif

  assign off         = tl_i.a_address - BaseAddr;
  assign mem_addr_o  = off[AW+1:2];
  assign mem_wdata_o = tl_i.a_data;
  assign mem_wmask_o = mask_expand(tl_i.a_mask);

  always_comb begin
    acc_meta          = '0;
    acc_meta.d_opcode = (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
    acc_meta.d_size   = tl_i.a_size;
    acc_meta.d_source = tl_i.a_source;
    acc_meta.error    = err;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
      pend_meta  <= '0;
    end else begin
      pend_valid <= acc;
      if (acc) pend_meta <= acc_meta;
    end
  end

  // Read data is only valid in the pending cycle, so it is captured on the push.
  always_comb begin
    pend_entry      = '0;
    pend_entry.meta = pend_meta;
    if (pend_valid && pend_meta.d_opcode == AccessAckData && !pend_meta.error) begin
      pend_entry.data = mem_rdata_i;
    end
  end

  assign pop  = !fifo_empty && tl_i.d_ready;
  assign push = pend_valid && !(fifo_empty && tl_i.d_ready);

  tlul_rsp_fifo #(
    .Depth (Depth),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (pend_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_entry = fifo_empty ? pend_entry : head;

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready;
    tl_o.d_user   = TL_D_USER_DEFAULT;
    tl_o.d_valid  = !fifo_empty || pend_valid;
    tl_o.d_opcode = out_entry.meta.d_opcode;
    tl_o.d_size   = out_entry.meta.d_size;
    tl_o.d_source = out_entry.meta.d_source;
    tl_o.d_error  = out_entry.meta.error;
    tl_o.d_data   = out_entry.data;
  end

  assign unused_sig = ^{tl_i.a_param, off[31:AW+2], off[1:0], fifo_full};

endmodule

// File: tb/tb_tlul_rsp_mem.sv
// Self-checking bench for tlul_rsp_mem: vector table of single transactions plus
// hand-written back-to-back, backpressure and mid-operation reset sequences.
module tb_tlul_rsp_mem;
  import tlul_pkg::*;

`ifdef TLUL_RSP_MEM_WRPROT_EN
  localparam bit ROM = 1'b1;
`else
  localparam bit ROM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_wmask, mem_rdata;
  logic [31:0] mem_model [1024];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tlul_rsp_mem #(
    .AW       (10),
    .BaseAddr (32'h0),
    .Depth    (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_i        (tl_i),
    .tl_o        (tl_o),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wmask_o (mem_wmask),
    .mem_rdata_i (mem_rdata)
  );

  // Synchronous single-port memory with byte-lane write mask.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) mem_model[mem_addr] <= (mem_model[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      mem_rdata <= mem_model[mem_addr];
    end
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        exp_req;
    logic        exp_we;
    logic [2:0]  exp_dop;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = tl_a_op_e'(op);
    tl_i.a_size    = size;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
  endtask

  task automatic driveGet(input logic [31:0] addr, input logic [7:0] src);
    applyStimulus(3'h4, 2'd2, addr, 4'hf, 32'h0, src);
  endtask

  task automatic runVector(input vec_t v, input logic [7:0] src);
    @(negedge clk);
    tl_i.d_ready = 1'b1;
    applyStimulus(v.op, v.size, v.addr, v.mask, v.data, src);
    #1;
    checkOutput({v.name, ".a_ready"}, 32'(tl_o.a_ready), 32'd1);
    checkOutput({v.name, ".mem_req"}, 32'(mem_req), 32'(v.exp_req));
    checkOutput({v.name, ".mem_we"}, 32'(mem_we), 32'(v.exp_we));
    if (v.exp_req) checkOutput({v.name, ".mem_addr"}, 32'(mem_addr), 32'(v.addr[11:2]));
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    #1;
    checkOutput({v.name, ".d_valid"}, 32'(tl_o.d_valid), 32'd1);
    checkOutput({v.name, ".d_opcode"}, 32'(tl_o.d_opcode), 32'(v.exp_dop));
    checkOutput({v.name, ".d_error"}, 32'(tl_o.d_error), 32'(v.exp_err));
    checkOutput({v.name, ".d_data"}, tl_o.d_data, v.exp_data);
    checkOutput({v.name, ".d_source"}, 32'(tl_o.d_source), 32'(src));
    checkOutput({v.name, ".d_size"}, 32'(tl_o.d_size), 32'(v.size));
  endtask

  vec_t vecs[17];
  logic [31:0] b2b_data[4];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
    mem_model[10'h020] = 32'hDEADBEEF;
    mem_model[10'h021] = 32'h11110001;
    mem_model[10'h022] = 32'h11110002;
    mem_model[10'h023] = 32'h11110003;
    mem_model[10'h040] = 32'hAAAAAAAA;
    mem_model[10'h3FF] = 32'hCAFEF00D;
    mem_rdata = 32'h0;

    //          name                 op     sz     addr       mask     data          req   we    dop   err  exp_data
    vecs[0]  = '{"get_basic",        3'h4, 2'd2, 32'h080, 4'b1111, 32'h0,        1'b1, 1'b0, 3'h1, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{"put_partial",      3'h1, 2'd2, 32'h100, 4'b0011, 32'h12345678, !ROM, !ROM, 3'h0, ROM,  32'h0};
    vecs[2]  = '{"get_after_partial",3'h4, 2'd2, 32'h100, 4'b1111, 32'h0,        1'b1, 1'b0, 3'h1, 1'b0,
                 ROM ? 32'hAAAAAAAA : 32'hAAAA5678};
    vecs[3]  = '{"get_misaligned",   3'h4, 2'd2, 32'h102, 4'b1111, 32'h0,        1'b0, 1'b0, 3'h1, 1'b1, 32'h0};
    vecs[4]  = '{"get_out_of_range", 3'h4, 2'd2, 32'h1000,4'b1111, 32'h0,        1'b0, 1'b0, 3'h1, 1'b1, 32'h0};
    vecs[5]  = '{"put_full",         3'h0, 2'd2, 32'h104, 4'b1111, 32'h11223344, !ROM, !ROM, 3'h0, ROM,  32'h0};
    vecs[6]  = '{"get_after_full",   3'h4, 2'd2, 32'h104, 4'b1111, 32'h0,        1'b1, 1'b0, 3'h1, 1'b0,
                 ROM ? 32'h0 : 32'h11223344};
    vecs[7]  = '{"put_full_short",   3'h0, 2'd2, 32'h108, 4'b0011, 32'hFFFFFFFF, 1'b0, 1'b0, 3'h0, 1'b1, 32'h0};
    vecs[8]  = '{"bad_opcode",       3'h2, 2'd2, 32'h080, 4'b1111, 32'h0,        1'b0, 1'b0, 3'h0, 1'b1, 32'h0};
    vecs[9]  = '{"bad_size",         3'h4, 2'd3, 32'h080, 4'b1111, 32'h0,        1'b0, 1'b0, 3'h1, 1'b1, 32'h0};
    vecs[10] = '{"get_byte",         3'h4, 2'd0, 32'h081, 4'b0010, 32'h0,        1'b1, 1'b0, 3'h1, 1'b0, 32'hDEADBEEF};
    vecs[11] = '{"get_byte_badlane", 3'h4, 2'd0, 32'h081, 4'b0001, 32'h0,        1'b0, 1'b0, 3'h1, 1'b1, 32'h0};
    vecs[12] = '{"get_half_hi",      3'h4, 2'd1, 32'h082, 4'b1100, 32'h0,        1'b1, 1'b0, 3'h1, 1'b0, 32'hDEADBEEF};
    vecs[13] = '{"get_zero_mask",    3'h4, 2'd2, 32'h080, 4'b0000, 32'h0,        1'b0, 1'b0, 3'h1, 1'b1, 32'h0};
    vecs[14] = '{"put_byte",         3'h1, 2'd0, 32'h10A, 4'b0100, 32'h00CC0000, !ROM, !ROM, 3'h0, ROM,  32'h0};
    vecs[15] = '{"get_after_byte",   3'h4, 2'd2, 32'h108, 4'b1111, 32'h0,        1'b1, 1'b0, 3'h1, 1'b0,
                 ROM ? 32'h0 : 32'h00CC0000};
    vecs[16] = '{"get_last_word",    3'h4, 2'd2, 32'hFFC, 4'b1111, 32'h0,        1'b1, 1'b0, 3'h1, 1'b0, 32'hCAFEF00D};

    b2b_data = '{32'hDEADBEEF, 32'h11110001, 32'h11110002, 32'h11110003};

    rst = 1'b1;
    tl_i = '0;
    #2;
    checkOutput("reset.a_ready", 32'(tl_o.a_ready), 32'd0);
    checkOutput("reset.d_valid", 32'(tl_o.d_valid), 32'd0);
    checkOutput("reset.d_data", tl_o.d_data, 32'd0);
    checkOutput("reset.d_error", 32'(tl_o.d_error), 32'd0);
    checkOutput("reset.d_user", 32'(tl_o.d_user), 32'h1555);
    checkOutput("reset.mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset.mem_we", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_reset.a_ready", 32'(tl_o.a_ready), 32'd1);

    for (int i = 0; i < 17; i++) runVector(vecs[i], 8'(i + 1));

    // Back-to-back Gets: one response per cycle, in order.
    @(negedge clk);
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        driveGet(32'h80 + 32'(i * 4), 8'(8'h10 + i));
        #1;
        checkOutput("b2b.a_ready", 32'(tl_o.a_ready), 32'd1);
      end else begin
        tl_i.a_valid = 1'b0;
        #1;
      end
      if (i > 0) begin
        checkOutput("b2b.d_valid", 32'(tl_o.d_valid), 32'd1);
        checkOutput("b2b.d_data", tl_o.d_data, b2b_data[i-1]);
        checkOutput("b2b.d_source", 32'(tl_o.d_source), 32'(8'h10 + i - 1));
      end
      @(negedge clk);
    end
    #1;
    checkOutput("b2b.idle_d_valid", 32'(tl_o.d_valid), 32'd0);

    // Backpressure: two accepts then a_ready drops; payload stable until d_ready.
    @(negedge clk);
    tl_i.d_ready = 1'b0;
    driveGet(32'h80, 8'h20);
    #1;
    checkOutput("bp.c0.a_ready", 32'(tl_o.a_ready), 32'd1);
    checkOutput("bp.c0.d_valid", 32'(tl_o.d_valid), 32'd0);
    @(negedge clk);
    driveGet(32'h84, 8'h21);
    #1;
    checkOutput("bp.c1.a_ready", 32'(tl_o.a_ready), 32'd1);
    checkOutput("bp.c1.d_valid", 32'(tl_o.d_valid), 32'd1);
    checkOutput("bp.c1.d_data", tl_o.d_data, 32'hDEADBEEF);
    @(negedge clk);
    driveGet(32'h88, 8'h22);
    #1;
    checkOutput("bp.c2.a_ready", 32'(tl_o.a_ready), 32'd0);
    checkOutput("bp.c2.d_data", tl_o.d_data, 32'hDEADBEEF);
    checkOutput("bp.c2.d_source", 32'(tl_o.d_source), 32'h20);
    @(negedge clk);
    #1;
    checkOutput("bp.c3.a_ready", 32'(tl_o.a_ready), 32'd0);
    checkOutput("bp.c3.d_valid", 32'(tl_o.d_valid), 32'd1);
    checkOutput("bp.c3.d_data", tl_o.d_data, 32'hDEADBEEF);
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bp.c4.a_ready", 32'(tl_o.a_ready), 32'd1);
    checkOutput("bp.c4.d_valid", 32'(tl_o.d_valid), 32'd1);
    checkOutput("bp.c4.d_data", tl_o.d_data, 32'h11110001);
    checkOutput("bp.c4.d_source", 32'(tl_o.d_source), 32'h21);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    #1;
    checkOutput("bp.c5.d_valid", 32'(tl_o.d_valid), 32'd1);
    checkOutput("bp.c5.d_data", tl_o.d_data, 32'h11110002);
    checkOutput("bp.c5.d_source", 32'(tl_o.d_source), 32'h22);
    @(negedge clk);
    #1;
    checkOutput("bp.c6.d_valid", 32'(tl_o.d_valid), 32'd0);

    // Reset while two responses are held: everything in flight is dropped.
    @(negedge clk);
    tl_i.d_ready = 1'b0;
    driveGet(32'h80, 8'h30);
    @(negedge clk);
    driveGet(32'h84, 8'h31);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    #1;
    checkOutput("rst_mid.held_d_valid", 32'(tl_o.d_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid.d_valid", 32'(tl_o.d_valid), 32'd0);
    checkOutput("rst_mid.a_ready", 32'(tl_o.a_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid.release_a_ready", 32'(tl_o.a_ready), 32'd1);
    checkOutput("rst_mid.release_d_valid", 32'(tl_o.d_valid), 32'd0);
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_mid.no_stale", 32'(tl_o.d_valid), 32'd0);
    end
    runVector(vecs[0], 8'h40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
